// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle for seg_scan_decoder: multiplexed segment/strobe inputs and decoded outputs.
// err_count is present only when SEG_ERR_CNT_EN is defined.
interface seg_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
`ifdef SEG_ERR_CNT_EN
    ,
    parameter int unsigned ERR_CNT_W  = 8
`endif
) ();
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    pattern_err;
`ifdef SEG_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]    err_count;
`endif

    modport master (
`ifdef SEG_ERR_CNT_EN
        input  err_count,
`endif
        output seg, digit_en, err_clr,
        input  bcd_out, digit_valid, frame_valid, pattern_err
    );

    modport slave (
`ifdef SEG_ERR_CNT_EN
        output err_count,
`endif
        input  seg, digit_en, err_clr,
        output bcd_out, digit_valid, frame_valid, pattern_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Debounces a multiplexed active-low 7-segment bus and rebuilds the per-digit BCD values.
// Optional illegal-commit counter enabled by defining SEG_ERR_CNT_EN.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CYC = 4
`ifdef SEG_ERR_CNT_EN
    ,
    parameter int unsigned ERR_CNT_W  = 8
`endif
) (
    input logic               clk,
    input logic               reset,
    seg_scan_decoder_if.slave bus
);

    localparam int unsigned SW    = NUM_DIGITS + 7;
    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 1);

    logic [SW-1:0]           raw;
    logic [SW-1:0]           s_q;
    logic [CNT_W-1:0]        stab_cnt_q, stab_cnt_d;
    logic [NUM_DIGITS-1:0]   en_q;
    logic                    same;
    logic                    one_hot;
    logic                    commit;
    logic [3:0]              digit;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 4'd0;
            7'b1001111: decode = 4'd1;
            7'b0010010: decode = 4'd2;
            7'b0000110: decode = 4'd3;
            7'b1001100: decode = 4'd4;
            7'b0100100: decode = 4'd5;
            7'b0100000: decode = 4'd6;
            7'b0001111: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0000100: decode = 4'd9;
            7'b1111111: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    assign raw = {bus.seg, bus.digit_en};

    always_comb begin
        same    = (raw == s_q);
        en_q    = s_q[NUM_DIGITS-1:0];
        one_hot = (en_q != '0) && ((en_q & (en_q - 1'b1)) == '0);
        // Commit only on the count's transition into saturation, so a held pattern fires once.
        commit  = same && (stab_cnt_q == CNT_PRE) && one_hot;
        digit   = decode(s_q[SW-1 -: 7]);

        if (!same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        err_d   = bus.err_clr ? 1'b0 : err_q;
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en_q[i]) begin
                    bcd_d[4*i +: 4] = digit;
                    valid_d[i]      = (digit <= 4'd9);
                    seen_d[i]       = 1'b1;
                end
            end
            if (digit == 4'hE) begin
                err_d = 1'b1;
            end
            if (seen_d == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q        <= {7'h7F, {NUM_DIGITS{1'b0}}};
            stab_cnt_q <= '0;
            bcd_q      <= '1;
            valid_q    <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s_q        <= raw;
            stab_cnt_q <= stab_cnt_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.pattern_err = err_q;

`ifdef SEG_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Clear is applied first so a simultaneous illegal commit leaves the count at 1.
    always_comb begin
        err_cnt_d = bus.err_clr ? '0 : err_cnt_q;
        if (commit && (digit == 4'hE) && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYC=4).
// err_count checks are compiled in only when SEG_ERR_CNT_EN is defined.
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

`ifdef SEG_ERR_CNT_EN
    seg_scan_decoder_if #(.NUM_DIGITS(4), .ERR_CNT_W(8)) bus ();
    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYC(4), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    seg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();
    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    // Drive a pattern at the current negedge and hold it for n cycles.
    task automatic hold(input logic [6:0] s, input logic [3:0] en, input int n);
        bus.seg      = s;
        bus.digit_en = en;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        bus.seg      = 7'h7F;
        bus.digit_en = 4'b0000;
        bus.err_clr  = 1'b0;
        #1;
        n_cmp++;
        if (bus.bcd_out !== 16'hFFFF) begin
            n_bad++; $display("FAIL reset_bcd: got %h want ffff", bus.bcd_out);
        end
        n_cmp++;
        if ({bus.digit_valid, bus.frame_valid, bus.pattern_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000",
                              {bus.digit_valid, bus.frame_valid, bus.pattern_err});
        end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_errcnt: got %0d want 0", bus.err_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency;
        hold(7'b0010010, 4'b0001, 4);
        n_cmp++;
        if (bus.bcd_out[3:0] !== 4'hF || bus.digit_valid[0] !== 1'b0) begin
            n_bad++; $display("FAIL latency_edge4: got %h/%b want f/0",
                              bus.bcd_out[3:0], bus.digit_valid[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.bcd_out[3:0] !== 4'h2 || bus.digit_valid[0] !== 1'b1) begin
            n_bad++; $display("FAIL latency_edge5: got %h/%b want 2/1",
                              bus.bcd_out[3:0], bus.digit_valid[0]);
        end
    endtask

    task automatic test_glitch;
        logic saw3;
        saw3 = 1'b0;
        bus.seg      = 7'b0000110;
        bus.digit_en = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.bcd_out[7:4] === 4'h3) saw3 = 1'b1;
        end
        bus.seg = 7'b0100100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.bcd_out[7:4] === 4'h3) saw3 = 1'b1;
        end
        n_cmp++;
        if (saw3 !== 1'b0) begin
            n_bad++; $display("FAIL glitch_commit: got slice1=3 seen=%b want 0", saw3);
        end
        n_cmp++;
        if (bus.bcd_out[7:4] !== 4'h5 || bus.digit_valid[1] !== 1'b1) begin
            n_bad++; $display("FAIL glitch_final: got %h/%b want 5/1",
                              bus.bcd_out[7:4], bus.digit_valid[1]);
        end
    endtask

    task automatic test_scan;
        logic [6:0] pat [4];
        int         pulses;
        int         good_pulse;
        pat[0] = 7'b1001100;
        pat[1] = 7'b0000110;
        pat[2] = 7'b0010010;
        pat[3] = 7'b1001111;
        pulses     = 0;
        good_pulse = 0;
        // Discard the partial frame left by earlier tests.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            bus.seg      = pat[d];
            bus.digit_en = 4'(1 << d);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.frame_valid === 1'b1) begin
                    pulses++;
                    if (d == 3 && c == 4) good_pulse++;
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || good_pulse != 1) begin
            n_bad++; $display("FAIL scan_frame: got %0d pulses (%0d on digit3 commit) want 1/1",
                              pulses, good_pulse);
        end
        n_cmp++;
        if (bus.bcd_out !== 16'h1234) begin
            n_bad++; $display("FAIL scan_bcd: got %h want 1234", bus.bcd_out);
        end
        n_cmp++;
        if (bus.digit_valid !== 4'hF) begin
            n_bad++; $display("FAIL scan_valid: got %b want 1111", bus.digit_valid);
        end
    endtask

    task automatic test_errors;
        hold(7'b1010101, 4'b0100, 6);
        n_cmp++;
        if (bus.bcd_out[11:8] !== 4'hE || bus.digit_valid !== 4'b1011 || bus.pattern_err !== 1'b1)
        begin
            n_bad++; $display("FAIL err_illegal: got %h/%b/%b want e/1011/1",
                              bus.bcd_out[11:8], bus.digit_valid, bus.pattern_err);
        end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd1) begin
            n_bad++; $display("FAIL err_count1: got %0d want 1", bus.err_count);
        end
`endif
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.pattern_err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b want 0", bus.pattern_err);
        end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd0) begin
            n_bad++; $display("FAIL err_count_clear: got %0d want 0", bus.err_count);
        end
`endif
        hold(7'b0110110, 4'b0100, 6);
        hold(7'b1111110, 4'b0100, 6);
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd2) begin
            n_bad++; $display("FAIL err_count2: got %0d want 2", bus.err_count);
        end
`endif
        // Raise err_clr exactly on the commit edge of the next illegal pattern.
        hold(7'b0111111, 4'b0100, 4);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.pattern_err !== 1'b1 || bus.bcd_out[11:8] !== 4'hE) begin
            n_bad++; $display("FAIL err_clr_collide: got %b/%h want 1/e",
                              bus.pattern_err, bus.bcd_out[11:8]);
        end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd1) begin
            n_bad++; $display("FAIL err_count_collide: got %0d want 1", bus.err_count);
        end
`endif
    endtask

    task automatic test_blank_and_nohot;
        int pulses;
        pulses = 0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        hold(7'b1111111, 4'b0001, 6);
        n_cmp++;
        if (bus.bcd_out !== 16'h1E3F || bus.digit_valid !== 4'b1010 || bus.pattern_err !== 1'b0)
        begin
            n_bad++; $display("FAIL blank: got %h/%b/%b want 1e3f/1010/0",
                              bus.bcd_out, bus.digit_valid, bus.pattern_err);
        end
        bus.seg      = 7'b0000000;
        bus.digit_en = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) pulses++;
        end
        n_cmp++;
        if (bus.bcd_out !== 16'h1E3F || bus.digit_valid !== 4'b1010 || pulses != 0) begin
            n_bad++; $display("FAIL multihot: got %h/%b/%0d want 1e3f/1010/0",
                              bus.bcd_out, bus.digit_valid, pulses);
        end
        hold(7'b0000000, 4'b0000, 10);
        n_cmp++;
        if (bus.bcd_out !== 16'h1E3F || bus.pattern_err !== 1'b0) begin
            n_bad++; $display("FAIL nohot: got %h/%b want 1e3f/0", bus.bcd_out, bus.pattern_err);
        end
    endtask

    task automatic test_mid_reset;
        hold(7'b1010101, 4'b0010, 6);
        n_cmp++;
        if (bus.pattern_err !== 1'b1) begin
            n_bad++; $display("FAIL midreset_pre: got %b want 1", bus.pattern_err);
        end
        hold(7'b0010010, 4'b1000, 2);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.bcd_out !== 16'hFFFF) begin
            n_bad++; $display("FAIL midreset_bcd: got %h want ffff", bus.bcd_out);
        end
        n_cmp++;
        if (bus.digit_valid !== 4'b0000 || bus.pattern_err !== 1'b0) begin
            n_bad++; $display("FAIL midreset_flags: got %b/%b want 0000/0",
                              bus.digit_valid, bus.pattern_err);
        end
`ifdef SEG_ERR_CNT_EN
        n_cmp++;
        if (bus.err_count !== 8'd0) begin
            n_bad++; $display("FAIL midreset_errcnt: got %0d want 0", bus.err_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_scan();
        test_errors();
        test_blank_and_nohot();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
